// File: rtl/rocc_dispatch_pkg.sv
// Shared types and constants for the RoCC dispatch block and its response tracker.
package rocc_dispatch_pkg;

  localparam int TRANS_ID_BITS = 3;
  localparam int ROCC_XD_BIT   = 14;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } rocc_resp_t;

  typedef struct packed {
    rocc_cmd_t                cmd;
    logic [TRANS_ID_BITS-1:0] transId;
  } cmd_entry_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] transId;
    logic [4:0]               rd;
    logic                     killed;
  } trk_entry_t;

  // True when the instruction expects a destination register write.
  function automatic logic instrXd(input logic [31:0] instr);
    return instr[ROCC_XD_BIT];
  endfunction

endpackage

// File: rtl/rocc_resp_tracker.sv
// In-order FIFO of tags for commands already sent to the accelerator that still owe a response.
// kill_all marks every held entry (and any same-cycle push) so its response is dropped on return.
module rocc_resp_tracker
  import rocc_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstN,
  input  logic                   i_push,
  input  trk_entry_t             i_pushEntry,
  input  logic                   i_pop,
  input  logic                   i_killAll,
  output trk_entry_t             o_head,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  trk_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  trk_entry_t       w_pushEntry;

  assign w_pushEntry = '{transId: i_pushEntry.transId,
                         rd:      i_pushEntry.rd,
                         killed:  i_pushEntry.killed | i_killAll};

  // Entry storage: a kill marks everything held, a push writes the tail slot.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_killAll) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i].killed <= 1'b1;
      end
      if (i_push) r_mem[r_wrPtr] <= w_pushEntry;
    end
  end

  // Wrapping pointers plus a separate occupancy count that drives empty.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // The dispatcher's reservation limit must keep the tracker from overflowing.
  assert property (@(posedge i_clk) disable iff (!i_rstN)
                   i_push |-> ((r_count != CNT_W'(DEPTH)) || i_pop));

endmodule

// File: rtl/rocc_dispatch.sv
// Forwards RoCC instructions to an accelerator through a small command queue, tracks the
// ones that need a register result, and returns every completion on one writeback port.
module rocc_dispatch
  import rocc_dispatch_pkg::*;
#(
  parameter int CMD_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     rocc_valid_i,
  output logic                     rocc_ready_o,
  input  logic [31:0]              rocc_instr_i,
  input  logic [63:0]              operand_a_i,
  input  logic [63:0]              operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output rocc_cmd_t                cmd_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  rocc_resp_t               resp_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [63:0]              wb_data_o
);

  localparam int Q_PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int Q_CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int R_CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  cmd_entry_t               r_qMem [CMD_DEPTH];
  logic [Q_PTR_W-1:0]       r_qRdPtr;
  logic [Q_PTR_W-1:0]       r_qWrPtr;
  logic [Q_CNT_W-1:0]       r_qCount;
  logic [R_CNT_W-1:0]       r_resvCount;
  logic                     r_wbValid;
  logic [TRANS_ID_BITS-1:0] r_wbTransId;
  logic [63:0]              r_wbData;

  cmd_entry_t               w_qHead;
  logic                     w_headXd;
  logic                     w_accept;
  logic                     w_acceptXd;
  logic                     w_cmdFire;
  logic                     w_xd0Fire;
  logic                     w_trkPush;
  logic                     w_respFire;
  trk_entry_t               w_trkPushEntry;
  trk_entry_t               w_trkHead;
  logic                     w_trkEmpty;
  logic [R_CNT_W-1:0]       w_trkCount;

  assign w_qHead      = r_qMem[r_qRdPtr];
  assign w_headXd     = instrXd(w_qHead.cmd.instr);
  assign rocc_ready_o = (r_qCount != Q_CNT_W'(CMD_DEPTH)) &&
                        (r_resvCount < R_CNT_W'(MAX_OUTSTANDING));
  assign w_accept     = rocc_valid_i && rocc_ready_o && !flush_i;
  assign w_acceptXd   = w_accept && instrXd(rocc_instr_i);
  assign cmd_valid_o  = (r_qCount != '0);
  assign cmd_o        = w_qHead.cmd;
  assign w_cmdFire    = cmd_valid_o && cmd_ready_i;
  assign w_xd0Fire    = w_cmdFire && !w_headXd;
  assign w_trkPush    = w_cmdFire && w_headXd;
  assign resp_ready_o = !w_trkEmpty && !w_xd0Fire;
  assign w_respFire   = resp_valid_i && resp_ready_o;

  assign w_trkPushEntry = '{transId: w_qHead.transId,
                            rd:      w_qHead.cmd.instr[11:7],
                            killed:  1'b0};

  // Command queue storage, written at the tail on every accepted instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CMD_DEPTH; i++) r_qMem[i] <= '0;
    end else if (w_accept) begin
      r_qMem[r_qWrPtr] <= '{cmd: '{instr: rocc_instr_i, rs1: operand_a_i, rs2: operand_b_i},
                            transId: trans_id_i};
    end
  end

  // Queue pointers and count; a flush empties the queue outright.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_qRdPtr <= '0;
      r_qWrPtr <= '0;
      r_qCount <= '0;
    end else if (flush_i) begin
      r_qRdPtr <= '0;
      r_qWrPtr <= '0;
      r_qCount <= '0;
    end else begin
      if (w_accept)  r_qWrPtr <= r_qWrPtr + Q_PTR_W'(1);
      if (w_cmdFire) r_qRdPtr <= r_qRdPtr + Q_PTR_W'(1);
      r_qCount <= r_qCount + Q_CNT_W'(w_accept) - Q_CNT_W'(w_cmdFire);
    end
  end

  // Reservations follow accepts and response pops; a flush resyncs them to the tracker occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resvCount <= '0;
    end else if (flush_i) begin
      r_resvCount <= w_trkCount + R_CNT_W'(w_trkPush) - R_CNT_W'(w_respFire);
    end else begin
      r_resvCount <= r_resvCount + R_CNT_W'(w_acceptXd) - R_CNT_W'(w_respFire);
    end
  end

  // Single writeback register shared by xd=0 completions and live accelerator responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wbValid   <= 1'b0;
      r_wbTransId <= '0;
      r_wbData    <= '0;
    end else if (flush_i) begin
      r_wbValid   <= 1'b0;
      r_wbTransId <= '0;
      r_wbData    <= '0;
    end else if (w_xd0Fire) begin
      r_wbValid   <= 1'b1;
      r_wbTransId <= w_qHead.transId;
      r_wbData    <= '0;
    end else if (w_respFire && !w_trkHead.killed) begin
      r_wbValid   <= 1'b1;
      r_wbTransId <= w_trkHead.transId;
      r_wbData    <= resp_i.data;
    end else begin
      r_wbValid   <= 1'b0;
    end
  end

  assign wb_valid_o    = r_wbValid;
  assign wb_trans_id_o = r_wbTransId;
  assign wb_data_o     = r_wbData;

  rocc_resp_tracker #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tracker (
    .i_clk       (clk_i),
    .i_rstN      (rst_ni),
    .i_push      (w_trkPush),
    .i_pushEntry (w_trkPushEntry),
    .i_pop       (w_respFire),
    .i_killAll   (flush_i),
    .o_head      (w_trkHead),
    .o_empty     (w_trkEmpty),
    .o_count     (w_trkCount)
  );

  // Responses come back strictly in order, so the returned rd must match the oldest tracked command.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   w_respFire |-> (resp_i.rd == w_trkHead.rd));

endmodule

// File: tb/tb_rocc_dispatch.sv
// Directed bench for rocc_dispatch with a writeback scoreboard checked by an independent monitor.
module tb_rocc_dispatch;
  import rocc_dispatch_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     flush_i = 1'b0;
  logic                     rocc_valid_i = 1'b0;
  logic                     rocc_ready_o;
  logic [31:0]              rocc_instr_i = '0;
  logic [63:0]              operand_a_i = '0;
  logic [63:0]              operand_b_i = '0;
  logic [TRANS_ID_BITS-1:0] trans_id_i = '0;
  logic                     cmd_valid_o;
  logic                     cmd_ready_i = 1'b0;
  rocc_cmd_t                cmd_o;
  logic                     resp_valid_i = 1'b0;
  logic                     resp_ready_o;
  rocc_resp_t               resp_i = '0;
  logic                     wb_valid_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [63:0]              wb_data_o;

  typedef struct {
    logic [TRANS_ID_BITS-1:0] tid;
    logic [63:0]              data;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  rocc_dispatch #(.CMD_DEPTH(2), .MAX_OUTSTANDING(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .rocc_valid_i  (rocc_valid_i),
    .rocc_ready_o  (rocc_ready_o),
    .rocc_instr_i  (rocc_instr_i),
    .operand_a_i   (operand_a_i),
    .operand_b_i   (operand_b_i),
    .trans_id_i    (trans_id_i),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .cmd_o         (cmd_o),
    .resp_valid_i  (resp_valid_i),
    .resp_ready_o  (resp_ready_o),
    .resp_i        (resp_i),
    .wb_valid_o    (wb_valid_o),
    .wb_trans_id_o (wb_trans_id_o),
    .wb_data_o     (wb_data_o)
  );

  // Free-running clock, period 10.
  always #5 clk_i = ~clk_i;

  // Hard time limit so the bench always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mkInstr(input logic xd, input logic [4:0] rd, input logic [6:0] funct);
    return {funct, 5'd2, 5'd1, xd, 1'b1, 1'b1, rd, 7'b0001011};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expectWb(input logic [TRANS_ID_BITS-1:0] tid, input logic [63:0] data);
    exp_t e;
    e.tid  = tid;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Present one instruction and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [31:0] instr, input logic [TRANS_ID_BITS-1:0] tid,
                               input logic [63:0] a, input logic [63:0] b);
    int waitCycles = 0;
    rocc_valid_i = 1'b1;
    rocc_instr_i = instr;
    trans_id_i   = tid;
    operand_a_i  = a;
    operand_b_i  = b;
    while (!rocc_ready_o && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (!rocc_ready_o) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL issueTimeout: actual=rocc_ready_o 0 required=1 within 50 cycles");
    end
    tick();
    rocc_valid_i = 1'b0;
  endtask

  // Present one accelerator response and hold it until the handshake (bounded wait).
  task automatic driveResp(input logic [4:0] respRd, input logic [63:0] data);
    int waitCycles = 0;
    resp_valid_i = 1'b1;
    resp_i       = '{rd: respRd, data: data};
    while (!resp_ready_o && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (!resp_ready_o) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL respTimeout: actual=resp_ready_o 0 required=1 within 50 cycles");
    end
    tick();
    resp_valid_i = 1'b0;
  endtask

  // Monitor: every writeback must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpectedWb: actual tid=%0d data=%0h required no writeback",
                 wb_trans_id_o, wb_data_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sbTransId", 64'(wb_trans_id_o), 64'(e.tid));
        checkOutput("sbData", wb_data_o, e.data);
      end
    end
  end

  initial begin
    logic [31:0] i1, i2, i3;

    // Reset values
    #12;
    checkOutput("rstCmdValid", 64'(cmd_valid_o), 64'd0);
    checkOutput("rstRespReady", 64'(resp_ready_o), 64'd0);
    checkOutput("rstWbValid", 64'(wb_valid_o), 64'd0);
    checkOutput("rstWbTransId", 64'(wb_trans_id_o), 64'd0);
    checkOutput("rstWbData", wb_data_o, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    checkOutput("postRstRoccReady", 64'(rocc_ready_o), 64'd1);

    // 1: xd=0 completes with data 0, two cycles after issue
    tick();
    cmd_ready_i = 1'b1;
    expectWb(3'd3, 64'd0);
    rocc_valid_i = 1'b1;
    rocc_instr_i = mkInstr(1'b0, 5'd1, 7'h11);
    trans_id_i   = 3'd3;
    #1;
    checkOutput("t1NoFallThrough", 64'(cmd_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    rocc_valid_i = 1'b0;
    checkOutput("t1CmdValid", 64'(cmd_valid_o), 64'd1);
    checkOutput("t1CmdInstr", 64'(cmd_o.instr), 64'(mkInstr(1'b0, 5'd1, 7'h11)));
    checkOutput("t1WbNotYet", 64'(wb_valid_o), 64'd0);
    tick();
    checkOutput("t1WbValid", 64'(wb_valid_o), 64'd1);
    checkOutput("t1WbTransId", 64'(wb_trans_id_o), 64'd3);
    checkOutput("t1WbData", wb_data_o, 64'd0);
    checkOutput("t1QueueEmpty", 64'(cmd_valid_o), 64'd0);
    tick();
    checkOutput("t1WbOneCycle", 64'(wb_valid_o), 64'd0);

    // 2: xd=1 response returns after a delay, writeback one cycle after the handshake
    applyStimulus(mkInstr(1'b1, 5'd10, 7'h22), 3'd5, 64'h1, 64'h2);
    repeat (4) tick();
    checkOutput("t2RespReady", 64'(resp_ready_o), 64'd1);
    checkOutput("t2NoEarlyWb", 64'(wb_valid_o), 64'd0);
    expectWb(3'd5, 64'hDEAD_BEEF);
    driveResp(5'd10, 64'hDEAD_BEEF);
    checkOutput("t2WbValid", 64'(wb_valid_o), 64'd1);
    checkOutput("t2WbTransId", 64'(wb_trans_id_o), 64'd5);
    checkOutput("t2WbData", wb_data_o, 64'hDEAD_BEEF);
    checkOutput("t2TrackerEmpty", 64'(resp_ready_o), 64'd0);
    tick();

    // 3: backpressure fills the command queue; head is held stable, then drains in order
    cmd_ready_i = 1'b0;
    i1 = mkInstr(1'b1, 5'd1, 7'h31);
    i2 = mkInstr(1'b1, 5'd2, 7'h32);
    i3 = mkInstr(1'b1, 5'd3, 7'h33);
    applyStimulus(i1, 3'd1, 64'h111, 64'h1110);
    applyStimulus(i2, 3'd2, 64'h222, 64'h2220);
    checkOutput("t3QueueFullReady", 64'(rocc_ready_o), 64'd0);
    checkOutput("t3HeadInstr", 64'(cmd_o.instr), 64'(i1));
    checkOutput("t3HeadRs1", cmd_o.rs1, 64'h111);
    rocc_valid_i = 1'b1;
    rocc_instr_i = i3;
    trans_id_i   = 3'd4;
    operand_a_i  = 64'h333;
    operand_b_i  = 64'h3330;
    repeat (2) tick();
    checkOutput("t3HeadHeld", 64'(cmd_o.instr), 64'(i1));
    checkOutput("t3HeadRs2Held", cmd_o.rs2, 64'h1110);
    checkOutput("t3StillNotReady", 64'(rocc_ready_o), 64'd0);
    cmd_ready_i = 1'b1;
    tick();
    checkOutput("t3SecondInstr", 64'(cmd_o.instr), 64'(i2));
    tick();
    rocc_valid_i = 1'b0;
    checkOutput("t3ThirdInstr", 64'(cmd_o.instr), 64'(i3));
    checkOutput("t3ThirdRs1", cmd_o.rs1, 64'h333);
    tick();
    expectWb(3'd1, 64'hA1);
    expectWb(3'd2, 64'hA2);
    expectWb(3'd4, 64'hA3);
    driveResp(5'd1, 64'hA1);
    driveResp(5'd2, 64'hA2);
    driveResp(5'd3, 64'hA3);
    repeat (2) tick();

    // 4: four outstanding xd=1 commands exhaust reservations; one response frees a slot
    applyStimulus(mkInstr(1'b1, 5'd4, 7'h41), 3'd1, 64'h0, 64'h0);
    applyStimulus(mkInstr(1'b1, 5'd5, 7'h42), 3'd2, 64'h0, 64'h0);
    applyStimulus(mkInstr(1'b1, 5'd6, 7'h43), 3'd3, 64'h0, 64'h0);
    applyStimulus(mkInstr(1'b1, 5'd7, 7'h44), 3'd6, 64'h0, 64'h0);
    checkOutput("t4MaxOutstanding", 64'(rocc_ready_o), 64'd0);
    tick();
    checkOutput("t4StillBlocked", 64'(rocc_ready_o), 64'd0);
    expectWb(3'd1, 64'hB0);
    driveResp(5'd4, 64'hB0);
    checkOutput("t4ReadyAfterResp", 64'(rocc_ready_o), 64'd1);
    expectWb(3'd2, 64'hB1);
    expectWb(3'd3, 64'hB2);
    expectWb(3'd6, 64'hB3);
    driveResp(5'd5, 64'hB1);
    driveResp(5'd6, 64'hB2);
    driveResp(5'd7, 64'hB3);
    repeat (2) tick();

    // 5: xd=0 completion and a response collide; the response waits one cycle
    expectWb(3'd2, 64'hC0FFEE);
    applyStimulus(mkInstr(1'b1, 5'd8, 7'h51), 3'd2, 64'h0, 64'h0);
    expectWb(3'd7, 64'd0);
    // xd=0 writeback leaves first, so its expectation must precede the response's
    expQ.push_front(expQ.pop_back());
    applyStimulus(mkInstr(1'b0, 5'd0, 7'h52), 3'd7, 64'h0, 64'h0);
    resp_valid_i = 1'b1;
    resp_i       = '{rd: 5'd8, data: 64'hC0FFEE};
    checkOutput("t5RespGated", 64'(resp_ready_o), 64'd0);
    tick();
    checkOutput("t5Xd0WbTid", 64'(wb_trans_id_o), 64'd7);
    checkOutput("t5RespReadyNext", 64'(resp_ready_o), 64'd1);
    tick();
    resp_valid_i = 1'b0;
    checkOutput("t5RespWbValid", 64'(wb_valid_o), 64'd1);
    checkOutput("t5RespWbTid", 64'(wb_trans_id_o), 64'd2);
    checkOutput("t5RespWbData", wb_data_o, 64'hC0FFEE);
    tick();

    // 6: flush with two commands sent and one queued; late responses vanish
    applyStimulus(mkInstr(1'b1, 5'd11, 7'h61), 3'd1, 64'h0, 64'h0);
    applyStimulus(mkInstr(1'b1, 5'd12, 7'h62), 3'd2, 64'h0, 64'h0);
    tick();
    cmd_ready_i = 1'b0;
    applyStimulus(mkInstr(1'b1, 5'd13, 7'h63), 3'd3, 64'h0, 64'h0);
    checkOutput("t6Queued", 64'(cmd_valid_o), 64'd1);
    flush_i      = 1'b1;
    rocc_valid_i = 1'b1;
    rocc_instr_i = mkInstr(1'b0, 5'd0, 7'h64);
    trans_id_i   = 3'd6;
    tick();
    flush_i      = 1'b0;
    rocc_valid_i = 1'b0;
    checkOutput("t6QueueCleared", 64'(cmd_valid_o), 64'd0);
    checkOutput("t6ReadyAfterFlush", 64'(rocc_ready_o), 64'd1);
    checkOutput("t6NoWb", 64'(wb_valid_o), 64'd0);
    cmd_ready_i = 1'b1;
    tick();
    checkOutput("t6FlushDropsIssue", 64'(cmd_valid_o), 64'd0);
    driveResp(5'd11, 64'hE1);
    checkOutput("t6KilledResp1", 64'(wb_valid_o), 64'd0);
    driveResp(5'd12, 64'hE2);
    checkOutput("t6KilledResp2", 64'(wb_valid_o), 64'd0);
    checkOutput("t6TrackerDrained", 64'(resp_ready_o), 64'd0);
    checkOutput("t6RoccReady", 64'(rocc_ready_o), 64'd1);
    applyStimulus(mkInstr(1'b1, 5'd16, 7'h65), 3'd1, 64'h0, 64'h0);
    applyStimulus(mkInstr(1'b1, 5'd17, 7'h66), 3'd2, 64'h0, 64'h0);
    applyStimulus(mkInstr(1'b1, 5'd18, 7'h67), 3'd3, 64'h0, 64'h0);
    checkOutput("t6ResvThree", 64'(rocc_ready_o), 64'd1);
    applyStimulus(mkInstr(1'b1, 5'd19, 7'h68), 3'd4, 64'h0, 64'h0);
    checkOutput("t6ResvFour", 64'(rocc_ready_o), 64'd0);
    tick();
    expectWb(3'd1, 64'hF1);
    expectWb(3'd2, 64'hF2);
    expectWb(3'd3, 64'hF3);
    expectWb(3'd4, 64'hF4);
    driveResp(5'd16, 64'hF1);
    driveResp(5'd17, 64'hF2);
    driveResp(5'd18, 64'hF3);
    driveResp(5'd19, 64'hF4);
    repeat (2) tick();

    // Reset mid-operation: an outstanding response is no longer accepted
    applyStimulus(mkInstr(1'b1, 5'd9, 7'h71), 3'd5, 64'h0, 64'h0);
    tick();
    checkOutput("rstMidRespReady", 64'(resp_ready_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("rstMidRespCleared", 64'(resp_ready_o), 64'd0);
    checkOutput("rstMidCmdValid", 64'(cmd_valid_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    #1;
    checkOutput("rstMidRespAfter", 64'(resp_ready_o), 64'd0);
    checkOutput("rstMidRoccReady", 64'(rocc_ready_o), 64'd1);
    repeat (3) tick();

    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
